// File: rtl/acia_rx.sv
// 6551-style ACIA receiver: 16x oversampled, 5-8 data bits, optional parity (ACIA_RX_PARITY_EN), stop, break detect.
// Latency: rdrf rises 1 clk after the stop-bit sample; no backpressure, a byte finishing while rdrf=1 is dropped and ovr set.
module acia_rx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic [1:0] wl,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       rd_strobe,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       ovr,
  output logic       fe,
  output logic       pe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef ACIA_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_rxd_s1;
  logic       r_rxd_s2;
  logic [3:0] r_tcnt;
  logic [3:0] w_tcnt_nxt;
  logic [2:0] r_bcnt;
  logic [2:0] w_bcnt_nxt;
  logic [2:0] r_last;
  logic [2:0] w_last_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic       w_done;
  logic       w_frame_fe;
  logic       w_frame_pe;

  logic [7:0] r_rx_data;
  logic       r_rdrf;
  logic       r_ovr;
  logic       r_fe;
  logic       r_pe;

`ifdef ACIA_RX_PARITY_EN
  logic       r_par_en;
  logic       r_par_odd;
  logic       r_pe_frm;
  logic       w_pe_frm_nxt;
  logic       w_par_en_nxt;
  logic       w_par_odd_nxt;
`else
  logic       w_unused_parity;
  assign w_unused_parity = parity_en | parity_odd;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= rxd;
      r_rxd_s2 <= r_rxd_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_last_nxt  = r_last;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_frame_fe  = 1'b0;
`ifdef ACIA_RX_PARITY_EN
    w_pe_frm_nxt  = r_pe_frm;
    w_par_en_nxt  = r_par_en;
    w_par_odd_nxt = r_par_odd;
`endif
    if (baud_tick) begin
      w_tcnt_nxt = r_tcnt + 4'd1;
      case (r_state)
        S_IDLE: begin
          w_tcnt_nxt = 4'd0;
          if (!r_rxd_s2) begin
            // Frame format is captured here so mid-frame control writes wait for the next frame.
            w_state_nxt = S_START;
            w_bcnt_nxt  = 3'd0;
            w_last_nxt  = 3'd7 - {1'b0, wl};
            w_shift_nxt = 8'h00;
`ifdef ACIA_RX_PARITY_EN
            w_pe_frm_nxt  = 1'b0;
            w_par_en_nxt  = parity_en;
            w_par_odd_nxt = parity_odd;
`endif
          end
        end
        S_START: begin
          if (r_tcnt == 4'd7) begin
            w_tcnt_nxt  = 4'd0;
            w_state_nxt = r_rxd_s2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (r_tcnt == 4'd15) begin
            w_shift_nxt[r_bcnt] = r_rxd_s2;
            w_bcnt_nxt          = r_bcnt + 3'd1;
            if (r_bcnt == r_last) begin
`ifdef ACIA_RX_PARITY_EN
              w_state_nxt = r_par_en ? S_PARITY : S_STOP;
`else
              w_state_nxt = S_STOP;
`endif
            end
          end
        end
`ifdef ACIA_RX_PARITY_EN
        S_PARITY: begin
          if (r_tcnt == 4'd15) begin
            w_pe_frm_nxt = r_rxd_s2 ^ (^r_shift) ^ r_par_odd;
            w_state_nxt  = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (r_tcnt == 4'd15) begin
            w_done      = 1'b1;
            w_frame_fe  = ~r_rxd_s2;
            w_state_nxt = r_rxd_s2 ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          w_tcnt_nxt = 4'd0;
          if (r_rxd_s2) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

`ifdef ACIA_RX_PARITY_EN
  // The final parity verdict is formed in the PARITY state and held until the stop sample.
  assign w_frame_pe = r_pe_frm;
`else
  assign w_frame_pe = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt  <= 4'd0;
      r_bcnt  <= 3'd0;
      r_last  <= 3'd7;
      r_shift <= 8'h00;
`ifdef ACIA_RX_PARITY_EN
      r_pe_frm  <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
`endif
    end else begin
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_last  <= w_last_nxt;
      r_shift <= w_shift_nxt;
`ifdef ACIA_RX_PARITY_EN
      r_pe_frm  <= w_pe_frm_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_odd <= w_par_odd_nxt;
`endif
    end
  end

  // A completing byte beats a same-cycle CPU read, as if the register had been empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data <= 8'h00;
      r_rdrf    <= 1'b0;
      r_ovr     <= 1'b0;
      r_fe      <= 1'b0;
      r_pe      <= 1'b0;
    end else if (w_done) begin
      if (!r_rdrf || rd_strobe) begin
        r_rx_data <= r_shift;
        r_rdrf    <= 1'b1;
        r_fe      <= w_frame_fe;
        r_pe      <= w_frame_pe;
        if (rd_strobe) begin
          r_ovr <= 1'b0;
        end
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (rd_strobe) begin
      r_rdrf <= 1'b0;
      r_ovr  <= 1'b0;
      r_fe   <= 1'b0;
      r_pe   <= 1'b0;
    end
  end

  assign rx_data = r_rx_data;
  assign rdrf    = r_rdrf;
  assign ovr     = r_ovr;
  assign fe      = r_fe;
  assign pe      = r_pe;

endmodule

// File: tb/tb_acia_rx.sv
// Directed bench for acia_rx: 10 ns clock, baud_tick every 4 clks (one bit = 64 clks).
module tb_acia_rx;

  logic       clk;
  logic       reset_n;
  logic       baud_tick;
  logic       rxd;
  logic [1:0] wl;
  logic       parity_en;
  logic       parity_odd;
  logic       rd_strobe;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       ovr;
  logic       fe;
  logic       pe;

  int n_chk;
  int n_pass;
  int tick_div;

  acia_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .rxd        (rxd),
    .wl         (wl),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rd_strobe  (rd_strobe),
    .rx_data    (rx_data),
    .rdrf       (rdrf),
    .ovr        (ovr),
    .fe         (fe),
    .pe         (pe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    tick_div  = 0;
    forever begin
      @(negedge clk);
      tick_div  = (tick_div + 1) % 4;
      baud_tick = (tick_div == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bit_time(input int n);
    repeat (64 * n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                            input logic par_b, input logic stop_b);
    logic [7:0] dv;
    dv  = d;
    rxd = 1'b0;
    bit_time(1);
    for (int i = 0; i < nb; i++) begin
      rxd = dv[i];
      bit_time(1);
    end
    if (has_par) begin
      rxd = par_b;
      bit_time(1);
    end
    rxd = stop_b;
    bit_time(1);
  endtask

  task automatic cpu_read();
    @(negedge clk);
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    rxd        = 1'b1;
    wl         = 2'b00;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    rd_strobe  = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_rdrf", rdrf, 1'b0);
    chk("rst_flags", {ovr, fe, pe}, 3'b000);
    reset_n = 1'b1;
    bit_time(1);

    // 8-bit frame 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_rdrf", rdrf, 1'b1);
    chk("a5_flags", {ovr, fe, pe}, 3'b000);
    cpu_read();
    chk("a5_rd_rdrf", rdrf, 1'b0);
    bit_time(1);

    // 5-bit frame; upper line bits of 0xFF never transmitted
    wl = 2'b11;
    send_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1);
    chk("w5_data", rx_data, 8'h1F);
    chk("w5_rdrf", rdrf, 1'b1);
    cpu_read();
    chk("w5_rd_rdrf", rdrf, 1'b0);
    chk("w5_rd_hold", rx_data, 8'h1F);
    wl = 2'b00;
    bit_time(1);

    // overrun
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", ovr, 1'b1);
    chk("ovr_rdrf", rdrf, 1'b1);
    cpu_read();
    chk("ovr_rd_all", {rdrf, ovr, fe, pe}, 4'b0000);
    bit_time(1);

    // false start: 3 ticks low
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    bit_time(2);
    chk("glitch_rdrf", rdrf, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    chk("glitch_next", rx_data, 8'h3C);
    chk("glitch_next_rdrf", rdrf, 1'b1);
    cpu_read();
    bit_time(1);

    // break: zero stop bit then line held low 40 bit times
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
    bit_time(40);
    chk("brk_fe", fe, 1'b1);
    chk("brk_rdrf", rdrf, 1'b1);
    chk("brk_ovr", ovr, 1'b0);
    chk("brk_data", rx_data, 8'h00);
    cpu_read();
    bit_time(2);
    chk("brk_no_new", rdrf, 1'b0);
    rxd = 1'b1;
    bit_time(1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    chk("brk_after", rx_data, 8'h5A);
    chk("brk_after_fe", fe, 1'b0);
    bit_time(1);

    // asynchronous reset mid-frame while 0x5A still unread
    rxd = 1'b0;
    bit_time(3);
    reset_n = 1'b0;
    #1;
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_rdrf", rdrf, 1'b0);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    reset_n = 1'b1;
    bit_time(2);
    chk("mrst_idle", rdrf, 1'b0);
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
    chk("mrst_next", rx_data, 8'h96);
    cpu_read();
    bit_time(1);

    // word length change mid-frame: frame stays 5 bits
    wl = 2'b11;
    fork
      send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b1);
      begin
        bit_time(2);
        wl = 2'b00;
      end
    join
    bit_time(2);
    chk("wlchg_data", rx_data, 8'h0A);
    chk("wlchg_fe", fe, 1'b0);
    cpu_read();
    bit_time(1);

`ifdef ACIA_RX_PARITY_EN
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1);
    chk("par_bad_pe", pe, 1'b1);
    chk("par_bad_data", rx_data, 8'h01);
    cpu_read();
    bit_time(1);
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1);
    chk("par_ok_pe", pe, 1'b0);
    chk("par_ok_rdrf", rdrf, 1'b1);
    cpu_read();
`else
    parity_en  = 1'b1;
    parity_odd = 1'b1;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    chk("nopar_data", rx_data, 8'h81);
    chk("nopar_pe_fe", {fe, pe}, 2'b00);
    cpu_read();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/acia_rx.md
ACIA_RX -- requirements
Module: acia_rx

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 reset_n  input  1  asynchronous active-low reset.
REQ-003 baud_tick  input  1  one-clk pulse at 16x bit rate; oversampling enable.
REQ-004 rxd  input  1  asynchronous serial line, idle high.
REQ-005 wl  input  2  word length, 6551 control bits 6:5: 00=8, 01=7, 10=6, 11=5 data bits.
REQ-006 parity_en  input  1  parity slot present (used only with ACIA_RX_PARITY_EN).
REQ-007 parity_odd  input  1  1=odd, 0=even parity (used only with ACIA_RX_PARITY_EN).
REQ-008 rd_strobe  input  1  one-clk pulse on CPU read of receive data register.
REQ-009 rx_data  output  8  received byte, LSB first; unused upper bits 0.
REQ-010 rdrf  output  1  receive data register full (status bit 3).
REQ-011 ovr  output  1  overrun (status bit 2).
REQ-012 fe  output  1  framing error (status bit 1).
REQ-013 pe  output  1  parity error (status bit 0).

Function
REQ-014 rxd SHALL pass a 2-flop synchroniser; all decisions use the synchronised value.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; tick counter 4 bits, bit counter 3 bits.
REQ-016 IDLE: on synchronised rxd=0 at a baud_tick -> START, tick counter cleared.
REQ-017 START: on 8th baud_tick, rxd=1 -> IDLE (false start, no flags); rxd=0 -> DATA, counter cleared.
REQ-018 DATA: sample rxd every 16th baud_tick into shift register LSB first; after wl-selected count -> PARITY if parity active, else STOP.
REQ-019 PARITY: sample on 16th tick; mismatch against XOR(data) ^ parity_odd sets internal parity-error flag; -> STOP.
REQ-020 STOP: sample on 16th tick; byte completes same clk; rxd=1 -> IDLE; rxd=0 -> fe source set, -> BREAK.
REQ-021 BREAK: stay until synchronised rxd=1 at a baud_tick, then -> IDLE; no new byte while in BREAK.
REQ-022 Byte completion with rdrf=0: rx_data loaded, rdrf=1, fe/pe loaded from this frame, ovr unchanged.
REQ-023 Byte completion with rdrf=1 and no rd_strobe same clk: rx_data, fe, pe unchanged; ovr=1; byte lost.
REQ-024 rd_strobe without completion: rdrf, ovr, fe, pe cleared next clk; rx_data held.
REQ-025 rd_strobe and completion same clk: completion wins as if rdrf=0; rdrf=1, ovr=0, new data and flags.
REQ-026 baud_tick absent: state and counters SHALL hold; no timeout.
REQ-027 wl change mid-frame SHALL take effect only at next START.
REQ-028 Latency: rdrf rises 1 clk after the baud_tick sampling stop bit.

Reset
REQ-029 reset_n low SHALL force IDLE, counters 0, synchroniser to 1, rx_data=0x00, rdrf=ovr=fe=pe=0, immediately and asynchronously.
REQ-030 Reset mid-frame SHALL discard the partial frame; after release a new start bit is required.

Configuration
REQ-031 Macro ACIA_RX_PARITY_EN defined: PARITY state and parity_en/parity_odd honoured, pe reported.
REQ-032 ACIA_RX_PARITY_EN undefined: PARITY state absent, parity inputs ignored, pe constant 0, DATA goes directly to STOP.

Verification
REQ-033 wl=00, parity off, frame 0xA5 with valid stop -> rx_data=0xA5, rdrf=1, ovr=fe=pe=0.
REQ-034 wl=11, frame 5 bits 0x1F -> rx_data=0x1F, upper 3 bits 0; then rd_strobe -> rdrf=0, rx_data still 0x1F.
REQ-035 Two frames 0x11, 0x22 with no read -> rx_data=0x11, ovr=1; rd_strobe -> all flags 0.
REQ-036 rxd low 3 ticks then high (glitch) -> returns IDLE, rdrf=0; following 0x3C frame received correctly.
REQ-037 Stop bit 0 then line held low 40 bit times -> fe=1 with one byte only, stays BREAK until rxd high.
REQ-038 With ACIA_RX_PARITY_EN, parity_en=1, parity_odd=0, byte 0x01 with parity bit 0 -> pe=1; parity bit 1 -> pe=0.
